// File: rtl/ofm_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ PE groups share one next-layer RAM write port,
// granting fixed-length bursts and writing them to contiguous addresses from base_addr.
module ofm_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [15:0]               total_bursts,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [31:0]               wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ARB, BURST, DONE} state_t;

  state_t            state;
  logic [31:0]       addr;
  logic [15:0]       burst_cnt;
  logic [15:0]       total_q;
  logic [BT_W-1:0]   beat;
  logic [LG_W-1:0]   last_grant;
  logic [LG_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic              found;

  // Search starts just after the previous winner, so every requester gets a turn.
  always_comb begin
    pick_idx = last_grant;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last_grant) + k) % NUM_REQ]) begin
        found    = 1'b1;
        pick_idx = LG_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
    pick_onehot = NUM_REQ'(1) << pick_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      burst_cnt  <= '0;
      total_q    <= '0;
      beat       <= '0;
      last_grant <= LG_W'(NUM_REQ - 1);
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            burst_cnt <= '0;
            total_q   <= total_bursts;
            busy      <= 1'b1;
            if (total_bursts == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ARB;
            end
          end
        end
        ARB: begin
          if (found) begin
            grant      <= pick_onehot;
            last_grant <= pick_idx;
            beat       <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          // The granted requester's word is captured here, so writes trail grant by one cycle.
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= req_data[int'(last_grant)*DATA_W +: DATA_W];
          addr    <= addr + 32'd1;
          if (beat == BT_W'(BEATS - 1)) begin
            grant     <= '0;
            beat      <= '0;
            burst_cnt <= burst_cnt + 16'd1;
            if (burst_cnt + 16'd1 == total_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ARB;
            end
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_wr_arbiter.sv
// Self-checking bench for ofm_wr_arbiter: requesters advance their word on each granted cycle,
// and a round-robin/scoreboard model predicts grants, write addresses, data and done.
module tb_ofm_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [31:0]               base_addr;
  logic [15:0]               total_bursts;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      wr_en;
  logic [31:0]               wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;
  logic                      done;

  int checks = 0;
  int errors = 0;
  int mptr;
  int cnt[NUM_REQ];
  logic [7:0] salt;
  logic [NUM_REQ-1:0] first_grant;

  ofm_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .total_bursts(total_bursts), .req(req), .req_data(req_data), .grant(grant),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int i, input int n);
    return {8'(i), salt, 16'(n)};
  endfunction

  function automatic int oh2i(input logic [NUM_REQ-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = mk(i, cnt[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr  = NUM_REQ - 1;
  endtask

  // Runs one layer from start to the cycle after done, checking every cycle against the model.
  task automatic run_layer(input logic [31:0] base, input logic [15:0] total,
                           input logic [3:0] pat1, input logic [3:0] pat2,
                           input int chg_cyc, input int start2_cyc);
    int cyc, budget, wr_total, bursts, glen, done_cnt, done_cyc, cur, pick;
    int wcnt[NUM_REQ];
    logic [NUM_REQ-1:0] prev_grant, prev_req;
    logic [31:0] exp_addr;
    bit finished;
    salt = 8'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin cnt[i] = 0; wcnt[i] = 0; end
    wr_total = 0; bursts = 0; glen = 0; done_cnt = 0; done_cyc = 0; finished = 0;
    exp_addr = base;
    base_addr = base;
    total_bursts = total;
    req = pat1;
    drive_data();
    prev_grant = '0;
    prev_req = req;
    first_grant = '0;
    budget = int'(total) * (BEATS + 2) + 20;
    start = 1'b1;
    for (cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (start2_cyc > 0 && cyc == start2_cyc + 1) start = 1'b0;
      checks++;
      if (wr_en !== (prev_grant != 0)) begin
        errors++;
        $display("[TB] FAIL wr_en cyc %0d: got %b want %b", cyc, wr_en, prev_grant != 0);
      end
      if (prev_grant != 0 && wr_en === 1'b1) begin
        cur = oh2i(prev_grant);
        checks++;
        if (wr_addr !== exp_addr) begin
          errors++;
          $display("[TB] FAIL wr_addr cyc %0d: got %h want %h", cyc, wr_addr, exp_addr);
        end
        checks++;
        if (wr_data !== mk(cur, wcnt[cur])) begin
          errors++;
          $display("[TB] FAIL wr_data cyc %0d: got %h want %h", cyc, wr_data, mk(cur, wcnt[cur]));
        end
        exp_addr = exp_addr + 32'd1;
        wcnt[cur]++;
        wr_total++;
      end
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("[TB] FAIL grant_onehot cyc %0d: got %b want at most one bit", cyc, grant);
      end
      if (grant != 0 && prev_grant == 0) begin
        pick = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (pick < 0 && prev_req[(mptr + k) % NUM_REQ]) pick = (mptr + k) % NUM_REQ;
        checks++;
        if (pick < 0 || grant !== NUM_REQ'(1) << pick) begin
          errors++;
          $display("[TB] FAIL grant_pick cyc %0d: got %b want index %0d", cyc, grant, pick);
        end
        if (pick >= 0) mptr = pick;
        if (bursts == 0) first_grant = grant;
        bursts++;
        glen = 1;
      end else if (grant != 0) begin
        glen++;
        checks++;
        if (grant !== prev_grant) begin
          errors++;
          $display("[TB] FAIL grant_hold cyc %0d: got %b want %b", cyc, grant, prev_grant);
        end
      end else if (prev_grant != 0) begin
        checks++;
        if (glen != BEATS) begin
          errors++;
          $display("[TB] FAIL burst_len cyc %0d: got %0d want %0d", cyc, glen, BEATS);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        checks++;
        if (wr_total != int'(total) * BEATS) begin
          errors++;
          $display("[TB] FAIL done_early cyc %0d: writes %0d want %0d", cyc, wr_total, int'(total) * BEATS);
        end
      end else if (done_cnt > 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_after cyc %0d: got %b want 0", cyc, busy);
        end
        finished = 1;
      end
      for (int i = 0; i < NUM_REQ; i++) if (prev_grant[i]) cnt[i]++;
      if (cyc == chg_cyc) req = pat2;
      if (!finished && start2_cyc > 0 && cyc == start2_cyc) start = 1'b1;
      drive_data();
      prev_grant = grant;
      prev_req = req;
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL timeout: layer not finished after %0d cycles", budget);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (bursts != int'(total) || wr_total != int'(total) * BEATS) begin
      errors++;
      $display("[TB] FAIL totals: bursts %0d writes %0d want %0d/%0d", bursts, wr_total,
               int'(total), int'(total) * BEATS);
    end
    if (total == 16'd0) begin
      checks++;
      if (done_cyc != 1) begin
        errors++;
        $display("[TB] FAIL zero_done_cyc: got %0d want 1", done_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    req = 4'b1111;
    base_addr = 32'h0;
    total_bursts = 16'd1;
    req_data = '0;
    #3;
    checks++;
    if ({grant, wr_en, busy, done} !== 7'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: grant %b wr_en %b busy %b done %b addr %h data %h",
               grant, wr_en, busy, done, wr_addr, wr_data);
    end
    do_reset();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("[TB] FAIL idle_ignores_req: busy %b grant %b want 0/0", busy, grant);
    end
  endtask

  task automatic test_single();
    run_layer(32'h100, 16'd1, 4'b0001, 4'b0001, 0, 0);
    checks++;
    if (first_grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_grant: got %b want 0001", first_grant);
    end
  endtask

  task automatic test_all_req();
    do_reset();
    run_layer(32'h1000, 16'd8, 4'b1111, 4'b1111, 0, 0);
    checks++;
    if (mptr != 3) begin
      errors++;
      $display("[TB] FAIL rr_last: got %0d want 3", mptr);
    end
  endtask

  task automatic test_zero();
    run_layer(32'h500, 16'd0, 4'b1111, 4'b1111, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_layer(32'h300, 16'd2, 4'b0100, 4'b0010, 3, 5);
  endtask

  task automatic test_reset_midburst();
    int waited;
    base_addr = 32'h200;
    total_bursts = 16'd1;
    req = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waited = 0;
    while (grant == 4'b0 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0001 || wr_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beat2_state: grant %b wr_en %b want 0001/1", grant, wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, wr_en, busy, done} !== 7'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midburst_reset: grant %b wr_en %b busy %b done %b addr %h data %h",
               grant, wr_en, busy, done, wr_addr, wr_data);
    end
    do_reset();
    run_layer(32'h200, 16'd1, 4'b1111, 4'b1111, 0, 0);
    checks++;
    if (first_grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: got %b want 0001", first_grant);
    end
  endtask

  task automatic test_wrap();
    run_layer(32'hFFFF_FFFE, 16'd1, 4'b0001, 4'b0001, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] p1, p2;
    for (int n = 0; n < 6; n++) begin
      p1 = 4'($urandom_range(1, 15));
      p2 = 4'($urandom_range(1, 15));
      run_layer($urandom, 16'($urandom_range(1, 5)), p1, p2,
                int'($urandom_range(2, 20)), int'($urandom_range(2, 15)));
    end
  endtask

  initial begin
    mptr = NUM_REQ - 1;
    test_reset();
    test_single();
    test_all_req();
    test_zero();
    test_back_to_back();
    test_reset_midburst();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
